dm_arbiter: RTL
===============

# dm_arbiter

Round-robin arbiter that shares the single 512×16 data memory (one address, one write strobe, asynchronous read) among up to NREQ requesters, e.g. the CPU load/store path and a DMA/loader port. It registers the winning request, drives the memory for exactly one clock cycle, captures read data at the following rising edge and acknowledges the owner. It sits between the requesters and the data memory and is the only driver of the memory's address, data-in and write-enable pins.

## Interface
- NREQ, 2, number of requesters (legal 2..8)
- AW, 9, memory address width
- DW, 16, memory data width (signed data, passed through unmodified)

- clk  in  1  clock; all arbiter flops on rising edge (memory writes on falling edge)
- rst  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester request level; held until its ack
- we  in  NREQ  per-requester write (1) / read (0), valid with req
- addr  in  NREQ*AW  flat per-requester address, requester i at bits [i*AW +: AW]
- wdata  in  NREQ*DW  flat per-requester write data, same packing
- ack  out  NREQ  one-cycle completion pulse, one-hot or zero
- rdata  out  DW  read data, valid in the cycle ack is high (read or write)
- dm_addr  out  AW  to memory address
- dm_in  out  DW  to memory write data
- dm_w  out  1  to memory write enable
- dm_out  in  DW  from memory (combinational read)

## Operation
- States per access slot: IDLE (no owner) and ACCESS (owner register valid). Owner register holds idx, we, addr, wdata.
- Each rising edge: eligible = req with the current owner's bit masked off (owner is not re-granted back-to-back while its ack is pending). If eligible non-zero, pick winner by round-robin, load owner register, go/stay ACCESS; else go IDLE.
- Round-robin: search starts at (last winner + 1) mod NREQ; last winner = lowest priority. Pointer updates only on a grant. Reset pointer = NREQ-1 (requester 0 wins first).
- In ACCESS: dm_addr = owner addr, dm_in = owner wdata, dm_w = owner we. Memory writes on the falling edge inside the cycle.
- Same edge that leaves ACCESS: rdata <= dm_out, ack[owner idx] <= 1. For writes rdata holds the just-written value.
- In IDLE: dm_w = 0, dm_addr/dm_in hold last values.
- dm_w, dm_addr, dm_in driven directly from flops only (no combinational path from req), so dm_w is glitch-free across the falling edge.
- Requester must drop req, or present a new request, in the cycle it sees ack; a req still high then is treated as a new request.

## Timing
- Reset (rst low, asynchronous): state IDLE, ack = 0, rdata = 0, dm_w = 0, dm_addr = 0, dm_in = 0, pointer = NREQ-1. rst asserted during ACCESS before the falling edge forces dm_w low immediately; that write is not performed and no ack is issued.
- Latency: req sampled at edge k -> memory access during cycle k..k+1 -> ack and rdata at edge k+1 (visible cycle k+1). One access per cycle aggregate throughput.
- Single active requester: at best one access every 2 cycles (self-mask). Two or more active: back-to-back, rotating grants, no idle cycle.
- Simultaneous requests with the pointer at j: winner is the first set bit at j+1, j+2, … (wrapping).
- Address wrap: addr passed as-is; no range checks (all 2^AW addresses valid).

## Structure
- Package dm_arb_pkg: AW/DW default constants, state enum (IDLE, ACCESS), owner-record typedef (idx, we, addr, wdata).
- One sub-module: rr_picker, combinational (eligible vector, pointer) -> (one-hot grant, winner index, any). It is reused by other shared-resource arbiters.
- The bench instantiates the real data memory behind dm_arbiter.

## Test plan
- Reset then idle: rst low mid-cycle -> all outputs 0 at once; no ack for 10 cycles with req = 0.
- Single write/read: req0 we = 1 addr 0x005 wdata 0x7FFF, then read 0x005 -> ack0 one cycle after each sample, rdata = 0x7FFF both times; requests granted every 2nd cycle.
- Contention NREQ = 2: req0 and req1 high continuously, reads of 0x010 / 0x1FF -> grants alternate 0,1,0,1 starting with 0, one ack per cycle, rdata matches memory preload.
- Round-robin NREQ = 4: req = 4'b1011 held, pointer at reset -> grant order 0,1,3,0,1,3.
- Signed/edge data: write 0x8000 at 0x1FF, read back -> rdata = 0x8000 (−32768); address 0x1FF does not alias to 0x000.
- Reset mid-access: rst low while owner has we = 1 addr 0x020 wdata 0x1234, before the falling edge -> dm_w drops, memory at 0x020 unchanged, no ack after release.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The owner record is sized for the default 512x16 data memory.
package dm_arb_pkg;

    localparam int DM_AW     = 9;
    localparam int DM_DW     = 16;
    localparam int MAX_NREQ  = 8;
    localparam int IDX_W     = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             we;
        logic [DM_AW-1:0] addr;
        logic [DM_DW-1:0] wdata;
    } owner_t;

    function automatic logic [MAX_NREQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return MAX_NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first eligible requester after the pointer.
// The pointer position itself has the lowest priority.
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  eligible_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        int cand;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr_i) + k) % N;
            if (!any_o && eligible_i[cand]) begin
                any_o         = 1'b1;
                idx_o         = IW'(cand);
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin owner of the single data memory port: one registered access per
// cycle, ack and read data returned at the edge that closes the access.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = DM_AW,
    parameter int DW   = DM_DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    we_i,
    input  logic [NREQ*AW-1:0] addr_i,
    input  logic [NREQ*DW-1:0] wdata_i,
    output logic [NREQ-1:0]    ack_o,
    output logic [DW-1:0]      rdata_o,
    output logic [AW-1:0]      dm_addr_o,
    output logic [DW-1:0]      dm_in_o,
    output logic               dm_w_o,
    input  logic [DW-1:0]      dm_out_i
);

    localparam int IW = $clog2(NREQ);

    state_e          state_q;
    owner_t          owner_q;
    owner_t          owner_d;
    logic [IW-1:0]   ptr_q;
    logic [NREQ-1:0] ack_q;
    logic [DW-1:0]   rdata_q;
    logic [AW-1:0]   dm_addr_q;
    logic [DW-1:0]   dm_in_q;
    logic            dm_w_q;

    logic [NREQ-1:0] busy_mask;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   win_idx;
    logic            win_any;

    logic [AW-1:0]   req_addr  [NREQ];
    logic [DW-1:0]   req_wdata [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign req_addr[gi]  = addr_i[gi*AW +: AW];
        assign req_wdata[gi] = wdata_i[gi*DW +: DW];
    end

    // The owner whose ack is about to be issued must not be re-granted on the same edge.
    always_comb begin
        busy_mask = '0;
        if (state_q == ACCESS) begin
            busy_mask = NREQ'(idx_onehot(owner_q.idx));
        end
        eligible = req_i & ~busy_mask;
    end

    rr_picker #(
        .N  (NREQ),
        .IW (IW)
    ) u_picker (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .grant_o    (grant),
        .idx_o      (win_idx),
        .any_o      (win_any)
    );

    always_comb begin
        owner_d = owner_q;
        if (win_any) begin
            owner_d.idx   = IDX_W'(win_idx);
            owner_d.we    = |(grant & we_i);
            owner_d.addr  = req_addr[win_idx];
            owner_d.wdata = req_wdata[win_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= IW'(NREQ - 1);
            ack_q     <= '0;
            rdata_q   <= '0;
            dm_addr_q <= '0;
            dm_in_q   <= '0;
            dm_w_q    <= 1'b0;
        end else begin
            ack_q <= busy_mask;
            if (state_q == ACCESS) begin
                rdata_q <= dm_out_i;
            end
            if (win_any) begin
                state_q   <= ACCESS;
                owner_q   <= owner_d;
                ptr_q     <= win_idx;
                dm_addr_q <= owner_d.addr;
                dm_in_q   <= owner_d.wdata;
                dm_w_q    <= owner_d.we;
            end else begin
                state_q <= IDLE;
                dm_w_q  <= 1'b0;
            end
        end
    end

    // Memory pins come straight from flops so dm_w is stable across the falling edge.
    assign ack_o     = ack_q;
    assign rdata_o   = rdata_q;
    assign dm_addr_o = dm_addr_q;
    assign dm_in_o   = dm_in_q;
    assign dm_w_o    = dm_w_q;

endmodule
